fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end that replaces the single-instruction PC/IR fetch loop.
- Generates sequential fetch PCs and issues requests to the Icache. Buffers returned {pc, inst} pairs in a DEPTH-entry FIFO and presents them to ID_reg through a valid/ready handshake.
- Handles redirects from EX (jumps/branches) by flushing and discarding stale responses, and detects the 0x0000_0000 termination instruction.

---
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus bundle: Icache request/response,
// EX redirect and the ID-side valid/ready head port.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  logic                  ic_req_valid;
  logic                  ic_req_ready;
  logic [ADDR_WIDTH-1:0] ic_req_addr;
  logic                  ic_resp_valid;
  logic [INST_WIDTH-1:0] ic_resp_inst;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  id_valid;
  logic                  id_ready;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [INST_WIDTH-1:0] id_inst;

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready,
    input  ic_resp_valid, ic_resp_inst,
    input  redirect_valid, redirect_pc,
    output id_valid, id_pc, id_inst,
    input  id_ready
  );

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready,
    output ic_resp_valid, ic_resp_inst,
    output redirect_valid, redirect_pc,
    input  id_valid, id_pc, id_inst,
    output id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential PC gen, Icache requests, DEPTH FIFO to ID.
// Define FETCH_BYPASS_EN for a combinational empty-FIFO response bypass.
module fetch_queue #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      entry,
  fetch_queue_if.master              bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halt,
  output logic                       misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] INC =
    ADDR_WIDTH'(INST_WIDTH/8);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_REQ, S_WAIT, S_HALTED
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } slot_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  discard;
  slot_t                 mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;

  logic redirect;
  logic has_head;
  logic req_fire;
  logic resp_take;
  logic push;
  logic pop;
  logic halt_set;

  assign redirect  = bus.redirect_valid;
  assign has_head  = (count != '0);
  assign req_fire  = bus.ic_req_valid & bus.ic_req_ready;
  assign resp_take = (state == S_WAIT)
                   & bus.ic_resp_valid & ~discard;

  // With one request in flight, REQ implies nothing outstanding.
  assign bus.ic_req_valid = reset & (state == S_REQ)
                          & (count < FULL);
  assign bus.ic_req_addr  = fetch_pc;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass       = resp_take & ~has_head;
  assign bus.id_valid = has_head | (bypass & ~redirect);
  assign bus.id_pc    = has_head ? mem[rd_ptr].pc : req_pc;
  assign bus.id_inst  = has_head ? mem[rd_ptr].inst
                                 : bus.ic_resp_inst;
  assign pop          = has_head & bus.id_ready;
  assign push         = resp_take & ~(bypass & bus.id_ready);
`else
  assign bus.id_valid = has_head;
  assign bus.id_pc    = mem[rd_ptr].pc;
  assign bus.id_inst  = mem[rd_ptr].inst;
  assign pop          = has_head & bus.id_ready;
  assign push         = resp_take;
`endif

  assign halt_set = bus.id_valid & bus.id_ready & ~redirect
                  & (bus.id_inst == '0);

  always_ff @(posedge clk) begin
    if (reset & ~redirect & push) begin
      mem[wr_ptr] <= slot_t'{pc: req_pc,
                             inst: bus.ic_resp_inst};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_REQ;
      fetch_pc     <= entry;
      req_pc       <= '0;
      discard      <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      halt         <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (halt_set) halt <= 1'b1;
      if (redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        if (bus.redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
        // A request accepted now, or one still pending, is stale.
        if ((state == S_WAIT && !bus.ic_resp_valid) || req_fire) begin
          state   <= S_WAIT;
          discard <= 1'b1;
        end else begin
          state   <= S_REQ;
          discard <= 1'b0;
        end
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        unique case (state)
          S_REQ: begin
            if (req_fire) begin
              req_pc   <= fetch_pc;
              fetch_pc <= fetch_pc + INC;
              state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.ic_resp_valid) begin
              discard <= 1'b0;
              if (discard)
                state <= S_REQ;
              else if (bus.ic_resp_inst == '0)
                state <= S_HALTED;
              else
                state <= S_REQ;
            end
          end
          S_HALTED: state <= S_HALTED;
          default:  state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: Icache emulation, queue-based reference
// model checked every cycle, plus directed literal scenarios.
module tb_fetch_queue;
  localparam int AW    = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] entry;
  logic [CW-1:0] count;
  logic          halt;
  logic          misalign_err;

  fetch_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus();

  fetch_queue #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .entry(entry), .bus(bus),
    .count(count), .halt(halt), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // stimulus
  bit            s_rst, s_rdy, s_idr, s_rv;
  logic [AW-1:0] s_rpc, s_entry;
  int            lat;
  bit            rnd_lat, rnd_inst;
  logic [AW-1:0] zero_at;

  // reference model
  logic [AW+IW-1:0] m_q[$];
  logic [AW-1:0]    m_pc, m_req_pc;
  bit               m_out, m_halted, m_halt, m_mis, m_live;
  int               m_ep, m_req_ep;
  logic [AW-1:0]    acc_q[$];
  logic [AW-1:0]    pop_q[$];
  int               maxcnt;

  // Icache emulation
  bit            ic_busy;
  int            ic_timer;
  logic [IW-1:0] ic_inst;

  function automatic logic [IW-1:0] gen_inst(input logic [AW-1:0] a);
    if (a == zero_at) return '0;
    if (rnd_inst)
      return ($urandom_range(0, 15) == 0) ? '0 : IW'($urandom);
    return 32'h0000_0013;
  endfunction

  task automatic step();
    bit               exp_rv, resp, fire, dut_fire, kept;
    logic [AW+IW-1:0] hd;
    logic [AW-1:0]    rsp_pc;
    reset              = s_rst;
    entry              = s_entry;
    bus.ic_req_ready   = s_rdy;
    bus.id_ready       = s_idr;
    bus.redirect_valid = s_rv;
    bus.redirect_pc    = s_rpc;
    bus.ic_resp_valid  = ic_busy && ic_timer == 0;
    bus.ic_resp_inst   = ic_inst;
    @(negedge clk);
    resp     = bus.ic_resp_valid;
    dut_fire = bus.ic_req_valid && s_rdy;
    exp_rv   = !m_halted && !m_out && m_q.size() < DEPTH;
    if (s_rst && m_live) begin
      chk("req_valid", AW'(bus.ic_req_valid), AW'(exp_rv));
      if (exp_rv) chk("req_addr", bus.ic_req_addr, m_pc);
      chk("id_valid", AW'(bus.id_valid), AW'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        hd = m_q[0];
        chk("id_pc", bus.id_pc, hd[AW+IW-1:IW]);
        chk("id_inst", AW'(bus.id_inst), AW'(hd[IW-1:0]));
      end
      chk("count", AW'(count), AW'(m_q.size()));
      chk("halt", AW'(halt), AW'(m_halt));
      chk("misalign", AW'(misalign_err), AW'(m_mis));
    end
    if (!s_rst) begin
      m_q.delete();
      acc_q.delete();
      pop_q.delete();
      m_pc     = s_entry;
      m_out    = 0;
      m_halted = 0;
      m_halt   = 0;
      m_mis    = 0;
      m_live   = 1;
      m_ep++;
      ic_busy  = 0;
    end else begin
      fire   = exp_rv && s_rdy;
      kept   = resp && m_out && m_req_ep == m_ep && !s_rv;
      rsp_pc = m_req_pc;
      if (resp) m_out = 0;
      if (fire) begin
        acc_q.push_back(m_pc);
        m_req_pc = m_pc;
        m_req_ep = m_ep;
        m_out    = 1;
      end
      if (s_rv) begin
        m_q.delete();
        m_pc = {s_rpc[AW-1:2], 2'b00};
        if (s_rpc[1:0] != 2'b00) m_mis = 1;
        m_halted = 0;
        m_ep++;
      end else begin
        if (m_q.size() > 0 && s_idr) begin
          hd = m_q.pop_front();
          pop_q.push_back(hd[AW+IW-1:IW]);
          if (hd[IW-1:0] == '0) m_halt = 1;
        end
        if (kept) begin
          m_q.push_back({rsp_pc, bus.ic_resp_inst});
          if (bus.ic_resp_inst == '0) m_halted = 1;
        end
        if (fire) m_pc = m_pc + AW'(IW/8);
      end
      if (m_q.size() > maxcnt) maxcnt = m_q.size();
      if (resp) ic_busy = 0;
      else if (ic_busy) ic_timer--;
      if (dut_fire) begin
        ic_busy  = 1;
        ic_timer = lat - 1;
        ic_inst  = gen_inst(bus.ic_req_addr);
        if (rnd_lat) lat = $urandom_range(1, 4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input logic [AW-1:0] e);
    s_entry = e;
    s_rst   = 0;
    s_rv    = 0;
    step();
    step();
    chk("rst_count", AW'(count), '0);
    chk("rst_id_valid", AW'(bus.id_valid), '0);
    chk("rst_halt", AW'(halt), '0);
    chk("rst_misalign", AW'(misalign_err), '0);
    chk("rst_req_valid", AW'(bus.ic_req_valid), '0);
    s_rst = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    s_rst = 0; s_rdy = 1; s_idr = 1; s_rv = 0;
    s_rpc = '0; s_entry = '0;
    lat = 2; rnd_lat = 0; rnd_inst = 0; zero_at = '1;
    m_ep = 0; m_live = 0; maxcnt = 0;

    // sequential fetch, consumer always ready
    do_reset(64'h1000);
    maxcnt = 0;
    run(14);
    chk("p1_nreq", AW'(acc_q.size() >= 3), 1);
    chk("p1_npop", AW'(pop_q.size() >= 3), 1);
    for (int i = 0; i < 3; i++) begin
      if (acc_q.size() > i)
        chk("p1_req_pc", acc_q[i], 64'h1000 + AW'(4*i));
      if (pop_q.size() > i)
        chk("p1_id_pc", pop_q[i], 64'h1000 + AW'(4*i));
    end
    chk("p1_count_le1", AW'(maxcnt <= 1), 1);

    // fill with consumer stalled, then release one entry
    do_reset(64'h1000);
    s_idr = 0;
    run(30);
    chk("p2_nreq", AW'(acc_q.size()), 4);
    chk("p2_full", AW'(count), 4);
    chk("p2_no_req", AW'(bus.ic_req_valid), 0);
    s_idr = 1;
    step();
    s_idr = 0;
    chk("p2_after_pop", AW'(count), 3);
    run(10);
    chk("p2_nreq2", AW'(acc_q.size()), 5);
    chk("p2_refill", AW'(count), 4);

    // redirect while waiting for 0x100C
    do_reset(64'h1000);
    s_idr = 1; lat = 5;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_out && m_req_pc == 64'h100C) found = 1;
      else step();
    end
    chk("p3_reach", AW'(found), 1);
    acc_q.delete(); pop_q.delete();
    s_rv = 1; s_rpc = 64'h2000;
    step();
    s_rv = 0; lat = 2;
    run(30);
    chk("p3_nreq", AW'(acc_q.size() > 0), 1);
    if (acc_q.size() > 0) chk("p3_req_pc", acc_q[0], 64'h2000);
    chk("p3_npop", AW'(pop_q.size() > 0), 1);
    if (pop_q.size() > 0) chk("p3_id_pc", pop_q[0], 64'h2000);

    // redirect coinciding with a response, FIFO holding two
    do_reset(64'h1000);
    s_idr = 0; lat = 1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_q.size() == 2 && ic_busy && ic_timer == 0) found = 1;
      else step();
    end
    chk("p4_reach", AW'(found), 1);
    acc_q.delete();
    s_rv = 1; s_rpc = 64'h3000;
    step();
    s_rv = 0;
    chk("p4_flush", AW'(count), 0);
    chk("p4_id_valid", AW'(bus.id_valid), 0);
    run(4);
    chk("p4_nreq", AW'(acc_q.size() > 0), 1);
    if (acc_q.size() > 0) chk("p4_req_pc", acc_q[0], 64'h3000);

    // zero instruction consumed -> halt
    do_reset(64'h1000);
    s_idr = 1; lat = 2; zero_at = 64'h1010;
    run(40);
    chk("p5_halt", AW'(halt), 1);
    chk("p5_nreq", AW'(acc_q.size()), 5);
    if (acc_q.size() > 0) chk("p5_last_req", acc_q[$], 64'h1010);
    chk("p5_no_req", AW'(bus.ic_req_valid), 0);

    // zero instruction flushed before it is popped
    do_reset(64'h1000);
    s_idr = 0; zero_at = 64'h1004;
    run(20);
    chk("p5b_count", AW'(count), 2);
    chk("p5b_no_req", AW'(bus.ic_req_valid), 0);
    acc_q.delete();
    s_rv = 1; s_rpc = 64'h4000; zero_at = '1;
    step();
    s_rv = 0; s_idr = 1;
    run(20);
    chk("p5b_halt", AW'(halt), 0);
    chk("p5b_nreq", AW'(acc_q.size() > 0), 1);
    if (acc_q.size() > 0) chk("p5b_req_pc", acc_q[0], 64'h4000);

    // misaligned redirect
    acc_q.delete();
    s_rv = 1; s_rpc = 64'h2002;
    step();
    s_rv = 0;
    chk("p6_misalign", AW'(misalign_err), 1);
    run(10);
    chk("p6_sticky", AW'(misalign_err), 1);
    chk("p6_nreq", AW'(acc_q.size() > 0), 1);
    if (acc_q.size() > 0) chk("p6_req_pc", acc_q[0], 64'h2000);
    do_reset(64'h1000);

    // randomized traffic
    rnd_lat = 1; rnd_inst = 1; zero_at = '1;
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(0, 199) != 0);
      if (!s_rst) s_entry = {32'h0, $urandom} & ~64'h3;
      s_rdy = ($urandom_range(0, 3) != 0);
      s_idr = ($urandom_range(0, 2) != 0);
      s_rv  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)
        s_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | AW'($urandom_range(0, 15));
      else
        s_rpc = {32'h0, $urandom};
      if ($urandom_range(0, 3) != 0) s_rpc[1:0] = 2'b00;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
